// File: rtl/iexecute.sv
// -----------------------------------------------------------------------------
// iexecute -- execute stage of the 5-stage RISC-V pipeline.
//
// Selects forwarded operands, runs the ALU, resolves branches/jumps and owns
// the EX/MEM pipeline register. When the EX_MUL_EN macro is defined, an
// iterative shift-add multiplier (one multiplier bit per cycle) handles
// ALUControlE = 110 and raises BusyE so the hazard unit stalls IF/ID/EX.
// With EX_MUL_EN undefined, 110 produces 0 in one cycle and BusyE is 0.
//
// Ports:
//   clk, reset (async, active-low)
//   *E control/operands   : ID/EX register outputs
//   ForwardAE/ForwardBE   : 00 RDxE, 01 ResultW, 10 ALUResultM, 11 as 00
//   ResultW               : writeback value for forwarding
//   PCSrcE, PCTargetE     : fetch redirect and target (PCE + ImmExtE)
//   BusyE                 : stall request while the multiplier runs
//   *M outputs            : EX/MEM register contents
// -----------------------------------------------------------------------------
module iexecute #(
   parameter int XLEN       = 32,
   parameter int MUL_CYCLES = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            RegWriteE,
   input  logic            MemWriteE,
   input  logic            JumpE,
   input  logic            BranchE,
   input  logic            ALUSrcE,
   input  logic [1:0]      ResultSrcE,
   input  logic [2:0]      ALUControlE,
   input  logic [4:0]      RdE,
   input  logic [4:0]      Rs1E,
   input  logic [4:0]      Rs2E,
   input  logic [XLEN-1:0] RD1E,
   input  logic [XLEN-1:0] RD2E,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] ImmExtE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic [XLEN-1:0] ResultW,
   output logic            PCSrcE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            BusyE,
   output logic            RegWriteM,
   output logic            MemWriteM,
   output logic [1:0]      ResultSrcM,
   output logic [4:0]      RdM,
   output logic [XLEN-1:0] ALUResultM,
   output logic [XLEN-1:0] WriteDataM,
   output logic [XLEN-1:0] PCPlus4M
);

   // Register indices are consumed by the hazard unit, not here.
   logic unused_ok;
   assign unused_ok = ^{Rs1E, Rs2E};

   logic            reg_write_m_q,  reg_write_m_d;
   logic            mem_write_m_q,  mem_write_m_d;
   logic [1:0]      result_src_m_q, result_src_m_d;
   logic [4:0]      rd_m_q,         rd_m_d;
   logic [XLEN-1:0] alu_result_m_q, alu_result_m_d;
   logic [XLEN-1:0] write_data_m_q, write_data_m_d;
   logic [XLEN-1:0] pc_plus4_m_q,   pc_plus4_m_d;

   logic [XLEN-1:0] src_a_e;
   logic [XLEN-1:0] src_b_e;
   logic [XLEN-1:0] write_data_e;
   logic [XLEN-1:0] alu_core_e;
   logic [XLEN-1:0] alu_result_e;
   logic            zero_e;
   logic            busy_e;

   // Operand forwarding; 11 falls back to the register-file value.
   always_comb begin
      case (ForwardAE)
         2'b01:   src_a_e = ResultW;
         2'b10:   src_a_e = alu_result_m_q;
         default: src_a_e = RD1E;
      endcase
      case (ForwardBE)
         2'b01:   write_data_e = ResultW;
         2'b10:   write_data_e = alu_result_m_q;
         default: write_data_e = RD2E;
      endcase
      src_b_e = ALUSrcE ? ImmExtE : write_data_e;
   end

   // Single-cycle ALU; mul (110) is handled by the multiplier when present.
   always_comb begin
      alu_core_e = '0;
      case (ALUControlE)
         3'b000:  alu_core_e = src_a_e + src_b_e;
         3'b001:  alu_core_e = src_a_e - src_b_e;
         3'b010:  alu_core_e = src_a_e & src_b_e;
         3'b011:  alu_core_e = src_a_e | src_b_e;
         3'b101:  alu_core_e = {{(XLEN-1){1'b0}}, ($signed(src_a_e) < $signed(src_b_e))};
         default: alu_core_e = '0;
      endcase
   end

`ifdef EX_MUL_EN
   localparam int CNT_W = $clog2(MUL_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] mul_a_q, mul_a_d;
   logic [XLEN-1:0] mul_b_q, mul_b_d;
   logic [XLEN-1:0] acc_q,   acc_d;
   logic [CNT_W-1:0] cnt_q,  cnt_d;
   logic            busy_c;

   // Operands are captured at issue because ResultW/ALUResultM move during
   // the stall. Each BUSY step adds the shifted multiplicand when the current
   // multiplier LSB is set; only the low XLEN bits are kept.
   always_comb begin
      state_d      = state_q;
      mul_a_d      = mul_a_q;
      mul_b_d      = mul_b_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      busy_c       = 1'b0;
      alu_result_e = alu_core_e;
      case (state_q)
         S_IDLE: begin
            if (ALUControlE == 3'b110) begin
               busy_c  = 1'b1;
               mul_a_d = src_a_e;
               mul_b_d = src_b_e;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            busy_c  = 1'b1;
            acc_d   = acc_q + (mul_b_q[0] ? mul_a_q : '0);
            mul_a_d = mul_a_q << 1;
            mul_b_d = mul_b_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            alu_result_e = acc_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         mul_a_q <= '0;
         mul_b_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   // While reset is held the FSM is IDLE, so a pending mul must not stall.
   assign busy_e = reset & busy_c;
`else
   localparam int unused_mul_cycles = MUL_CYCLES;

   assign alu_result_e = alu_core_e;
   assign busy_e       = 1'b0;
`endif

   assign zero_e    = (alu_result_e == '0);
   assign PCTargetE = PCE + ImmExtE;
   // No redirect while a multiply is being issued or iterated.
   assign PCSrcE    = reset & ~busy_e & (JumpE | (BranchE & zero_e));
   assign BusyE     = busy_e;

   // EX/MEM register input: a bubble while the multiplier holds the stage.
   always_comb begin
      reg_write_m_d  = 1'b0;
      mem_write_m_d  = 1'b0;
      result_src_m_d = '0;
      rd_m_d         = '0;
      alu_result_m_d = '0;
      write_data_m_d = '0;
      pc_plus4_m_d   = '0;
      if (!busy_e) begin
         reg_write_m_d  = RegWriteE;
         mem_write_m_d  = MemWriteE;
         result_src_m_d = ResultSrcE;
         rd_m_d         = RdE;
         alu_result_m_d = alu_result_e;
         write_data_m_d = write_data_e;
         pc_plus4_m_d   = PCPlus4E;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         reg_write_m_q  <= 1'b0;
         mem_write_m_q  <= 1'b0;
         result_src_m_q <= '0;
         rd_m_q         <= '0;
         alu_result_m_q <= '0;
         write_data_m_q <= '0;
         pc_plus4_m_q   <= '0;
      end else begin
         reg_write_m_q  <= reg_write_m_d;
         mem_write_m_q  <= mem_write_m_d;
         result_src_m_q <= result_src_m_d;
         rd_m_q         <= rd_m_d;
         alu_result_m_q <= alu_result_m_d;
         write_data_m_q <= write_data_m_d;
         pc_plus4_m_q   <= pc_plus4_m_d;
      end
   end

   assign RegWriteM  = reg_write_m_q;
   assign MemWriteM  = mem_write_m_q;
   assign ResultSrcM = result_src_m_q;
   assign RdM        = rd_m_q;
   assign ALUResultM = alu_result_m_q;
   assign WriteDataM = write_data_m_q;
   assign PCPlus4M   = pc_plus4_m_q;

endmodule

// File: tb/tb_iexecute.sv
// -----------------------------------------------------------------------------
// tb_iexecute -- scoreboard bench for the execute stage. Stimulus is applied
// on the falling edge; the expected EX/MEM contents are pushed into a queue
// and a monitor pops and compares them after every rising edge.
// -----------------------------------------------------------------------------
module tb_iexecute;
   localparam int XLEN       = 32;
   localparam int MUL_CYCLES = 32;

   logic            clk;
   logic            reset;
   logic            RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
   logic [1:0]      ResultSrcE;
   logic [2:0]      ALUControlE;
   logic [4:0]      RdE, Rs1E, Rs2E;
   logic [31:0]     RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
   logic [1:0]      ForwardAE, ForwardBE;
   logic [31:0]     ResultW;
   logic            PCSrcE;
   logic [31:0]     PCTargetE;
   logic            BusyE;
   logic            RegWriteM, MemWriteM;
   logic [1:0]      ResultSrcM;
   logic [4:0]      RdM;
   logic [31:0]     ALUResultM, WriteDataM, PCPlus4M;

   typedef struct packed {
      logic        rw;
      logic        mw;
      logic [1:0]  rs;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [31:0] pc4;
   } mrec_t;

   mrec_t       sb[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] alu_m_mdl;   // value the model expects on ALUResultM now

   iexecute #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) dut (
      .clk(clk), .reset(reset),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
      .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
      .ALUControlE(ALUControlE), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE),
      .PCPlus4E(PCPlus4E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .BusyE(BusyE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
      .ResultSrcM(ResultSrcM), .RdM(RdM), .ALUResultM(ALUResultM),
      .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd,
                                       input logic [31:0] rw, input logic [31:0] am);
      if (sel == 2'b01) return rw;
      if (sel == 2'b10) return am;
      return rd;
   endfunction

   function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
      case (op)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a & b;
         3'b011:  return a | b;
         3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // Monitor: one EX/MEM record per rising edge while out of reset.
   always @(posedge clk) begin
      mrec_t e;
      #1;
      if (reset && sb.size() != 0) begin
         e = sb.pop_front();
         chk("RegWriteM",  32'(RegWriteM),  32'(e.rw));
         chk("MemWriteM",  32'(MemWriteM),  32'(e.mw));
         chk("ResultSrcM", 32'(ResultSrcM), 32'(e.rs));
         chk("RdM",        32'(RdM),        32'(e.rd));
         chk("ALUResultM", ALUResultM,      e.alu);
         chk("WriteDataM", WriteDataM,      e.wd);
         chk("PCPlus4M",   PCPlus4M,        e.pc4);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic set_idle();
      RegWriteE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0; ALUSrcE = 0;
      ResultSrcE = 0; ALUControlE = 0; RdE = 0; Rs1E = 0; Rs2E = 0;
      RD1E = 0; RD2E = 0; PCE = 0; ImmExtE = 0; PCPlus4E = 0;
      ForwardAE = 0; ForwardBE = 0; ResultW = 0;
   endtask

   // Called just after a falling edge with inputs applied. Checks the
   // combinational outputs, queues the expected EX/MEM record, and waits
   // for the next falling edge.
   task automatic push_cycle(input logic exp_busy, input logic use_prod,
                             input logic [31:0] prod);
      logic [31:0] a, wd, b, res;
      logic        exp_pcsrc;
      mrec_t       e;
      a   = fwd(ForwardAE, RD1E, ResultW, alu_m_mdl);
      wd  = fwd(ForwardBE, RD2E, ResultW, alu_m_mdl);
      b   = ALUSrcE ? ImmExtE : wd;
      res = use_prod ? prod : alu(ALUControlE, a, b);
      exp_pcsrc = exp_busy ? 1'b0 : (JumpE | (BranchE & (res == 32'd0)));
      #1;
      chk("BusyE",     32'(BusyE),  32'(exp_busy));
      chk("PCSrcE",    32'(PCSrcE), 32'(exp_pcsrc));
      chk("PCTargetE", PCTargetE,   PCE + ImmExtE);
      if (exp_busy) e = '0;
      else e = '{rw: RegWriteE, mw: MemWriteE, rs: ResultSrcE, rd: RdE,
                 alu: res, wd: wd, pc4: PCPlus4E};
      sb.push_back(e);
      alu_m_mdl = e.alu;
      @(negedge clk);
   endtask

   // Asynchronous reset pulse starting mid-cycle; released on a falling edge.
   task automatic abort_reset();
      reset = 1'b0;
      #1;
      chk("rst_BusyE",      32'(BusyE),      32'd0);
      chk("rst_PCSrcE",     32'(PCSrcE),     32'd0);
      chk("rst_RegWriteM",  32'(RegWriteM),  32'd0);
      chk("rst_MemWriteM",  32'(MemWriteM),  32'd0);
      chk("rst_ResultSrcM", 32'(ResultSrcM), 32'd0);
      chk("rst_RdM",        32'(RdM),        32'd0);
      chk("rst_ALUResultM", ALUResultM,      32'd0);
      chk("rst_WriteDataM", WriteDataM,      32'd0);
      chk("rst_PCPlus4M",   PCPlus4M,        32'd0);
      sb.delete();
      alu_m_mdl = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic rand_instr();
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (op == 3'b110) op = 3'b101;
      ALUControlE = op;
      RegWriteE = 1'($urandom); MemWriteE = 1'($urandom);
      JumpE = ($urandom_range(0, 7) == 0); BranchE = 1'($urandom);
      ALUSrcE = 1'($urandom); ResultSrcE = 2'($urandom);
      RdE = 5'($urandom); Rs1E = 5'($urandom); Rs2E = 5'($urandom);
      RD1E = $urandom(); RD2E = $urandom(); PCE = $urandom();
      ImmExtE = $urandom(); PCPlus4E = PCE + 32'd4;
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
      ResultW = $urandom();
      if ($urandom_range(0, 3) == 0) begin
         RD2E = RD1E; ForwardAE = 0; ForwardBE = 0; ALUSrcE = 0;
         ALUControlE = 3'b001; BranchE = 1;
      end
   endtask

`ifdef EX_MUL_EN
   // Issue the mul currently on the inputs; product from plain arithmetic on
   // the operands visible at issue. abort_at >= 0 pulses reset at that cycle.
   task automatic do_mul(input int abort_at);
      logic [31:0] a, b, prod;
      a = fwd(ForwardAE, RD1E, ResultW, alu_m_mdl);
      b = ALUSrcE ? ImmExtE : fwd(ForwardBE, RD2E, ResultW, alu_m_mdl);
      prod = a * b;
      for (int i = 0; i <= MUL_CYCLES; i++) begin
         if (i == abort_at) begin
            abort_reset();
            return;
         end
         if (i > 0) ResultW = $urandom();
         push_cycle(1'b1, 1'b0, '0);
      end
      push_cycle(1'b0, 1'b1, prod);
   endtask
`endif

   initial begin
      set_idle();
      alu_m_mdl = '0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("init_BusyE",      32'(BusyE),     32'd0);
      chk("init_PCSrcE",     32'(PCSrcE),    32'd0);
      chk("init_RegWriteM",  32'(RegWriteM), 32'd0);
      chk("init_ALUResultM", ALUResultM,     32'd0);
      chk("init_PCPlus4M",   PCPlus4M,       32'd0);
      @(negedge clk);
      reset = 1'b1;

      // add x3 = 5 + 7
      set_idle(); RD1E = 5; ImmExtE = 7; ALUSrcE = 1; RdE = 3; RegWriteE = 1;
      PCPlus4E = 32'h44;
      push_cycle(1'b0, 1'b0, '0);

      // produce 0x10 on ALUResultM, then sub with both operands forwarded
      set_idle(); RD1E = 32'h10; ALUSrcE = 1; RdE = 4; RegWriteE = 1;
      push_cycle(1'b0, 1'b0, '0);
      set_idle(); ALUControlE = 3'b001; ForwardAE = 2'b10; ForwardBE = 2'b01;
      ResultW = 32'h3; RdE = 5; RegWriteE = 1; RD1E = 32'hDEAD; RD2E = 32'hBEEF;
      push_cycle(1'b0, 1'b0, '0);

      // beq taken, then not taken
      set_idle(); ALUControlE = 3'b001; BranchE = 1; RD1E = 9; RD2E = 9;
      PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8;
      push_cycle(1'b0, 1'b0, '0);
      RD2E = 8;
      push_cycle(1'b0, 1'b0, '0);

      // reset pulse with non-zero M contents
      set_idle(); RD1E = 32'h1234; RD2E = 32'h55; RdE = 7; RegWriteE = 1;
      MemWriteE = 1; PCPlus4E = 32'h88; ResultSrcE = 2'b10;
      push_cycle(1'b0, 1'b0, '0);
      abort_reset();

      for (int n = 0; n < 150; n++) begin
         rand_instr();
         push_cycle(1'b0, 1'b0, '0);
      end

`ifdef EX_MUL_EN
      // 0xFFFFFFFF * 3 with a jump pending to show redirect suppression
      set_idle(); ALUControlE = 3'b110; RD1E = 32'hFFFF_FFFF; RD2E = 3;
      RdE = 6; RegWriteE = 1; JumpE = 1; PCPlus4E = 32'h204;
      do_mul(-1);

      // abort at BUSY cycle 10, then a fresh mul must run to completion
      set_idle(); ALUControlE = 3'b110; RD1E = 32'h1357; RD2E = 32'h2468;
      RdE = 9; RegWriteE = 1;
      do_mul(10);
      set_idle(); ALUControlE = 3'b110; RD1E = 7; RD2E = 6; RdE = 10; RegWriteE = 1;
      do_mul(-1);
      // back-to-back mul
      set_idle(); ALUControlE = 3'b110; RD1E = 32'h8000_0001; ImmExtE = 32'hFFFF_FFFE;
      ALUSrcE = 1; RdE = 11; RegWriteE = 1;
      do_mul(-1);

      for (int n = 0; n < 3; n++) begin
         set_idle(); RD1E = $urandom(); ImmExtE = $urandom(); ALUSrcE = 1;
         RdE = 5'($urandom); RegWriteE = 1;
         push_cycle(1'b0, 1'b0, '0);
         rand_instr();
         ALUControlE = 3'b110; BranchE = 0; JumpE = 0;
         ForwardAE = (n == 0) ? 2'b10 : 2'($urandom);
         do_mul(-1);
      end
`else
      // mul without the multiplier: zero in one cycle, never busy
      set_idle(); ALUControlE = 3'b110; RD1E = 32'hFFFF_FFFF; RD2E = 3;
      RdE = 6; RegWriteE = 1; PCPlus4E = 32'h204;
      push_cycle(1'b0, 1'b0, '0);
      set_idle(); ALUControlE = 3'b110; RD1E = 7; RD2E = 6; RdE = 2; RegWriteE = 1;
      push_cycle(1'b0, 1'b0, '0);
`endif

      set_idle();
      @(posedge clk);
      #3;
      chk("scoreboard_drain", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
